// File: rtl/lc3_fetch_decode.sv
// LC-3 instruction fetch and decode front end. It runs an IDLE/READ/HOLD handshake
// between the control FSM and instruction memory, and presents the decoded instruction.
module lc3_fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] pc_in,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [15:0] ir,
    output logic [4:0]  opcode,
    output logic [15:0] pc_next,
    output logic        dec_valid,
    input  logic        dec_ack,
    output logic        illegal,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic        illegal_q, illegal_d;
    logic        fetch_err_d;

    // JSR/JSRR share opcode 0100 and JMP/RET share 1100; the sub-fields split them.
    function automatic logic [4:0] decode_op(input logic [15:0] insn);
        case (insn[15:12])
            4'b0100: decode_op = insn[11] ? 5'd4 : 5'd16;
            4'b1100: decode_op = (insn[8:6] == 3'b111) ? 5'd17 : 5'd12;
            default: decode_op = {1'b0, insn[15:12]};
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        ir_d        = ir_q;
        opcode_d    = opcode_q;
        pc_next_d   = pc_next_q;
        illegal_d   = illegal_q;
        fetch_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    addr_d  = pc_in;
                    wait_d  = 16'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (mem_rdy) begin
                    ir_d      = mem_rdata;
                    opcode_d  = decode_op(mem_rdata);
                    illegal_d = (mem_rdata[15:12] == 4'b1101);
                    pc_next_d = addr_q + 16'd1;
                    wait_d    = 16'd0;
                    state_d   = HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    wait_d      = 16'd0;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            HOLD: begin
                // Accepting a new request together with the ack avoids an IDLE bubble.
                if (dec_ack) begin
                    if (fetch_req) begin
                        addr_d  = pc_in;
                        wait_d  = 16'd0;
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= RESET_PC;
            wait_q    <= 16'd0;
            ir_q      <= 16'h0000;
            opcode_q  <= 5'd0;
            pc_next_q <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            pc_next_q <= pc_next_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_rd    = (state_q == READ);
    assign mem_addr  = addr_q;
    assign dec_valid = (state_q == HOLD);
    assign ir        = ir_q;
    assign opcode    = opcode_q;
    assign pc_next   = pc_next_q;
    assign illegal   = illegal_q;
    assign fetch_err = fetch_err_d;

endmodule

// File: doc/lc3_fetch_decode.md
LC3_FETCH_DECODE -- requirements
Module: lc3_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 16'h3000: value held in fetch address register after reset.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles the block waits for mem_rdy before aborting a fetch.
REQ-003 Clocks and resets: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 fetch_req  input  1  control FSM (FETCH0) requests a fetch at pc_in.
REQ-007 pc_in  input  16  instruction address to fetch.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_addr  output  16  memory read address.
REQ-010 mem_rdata  input  16  memory read data; valid when mem_rdy=1.
REQ-011 mem_rdy  input  1  memory read-complete indication.
REQ-012 ir  output  16  latched instruction register.
REQ-013 opcode  output  5  decoded opcode index: BR=0, ADD=1, LD=2, ST=3, JSR=4, AND=5, LDR=6, STR=7, RTI=8, NOT=9, LDI=10, STI=11, JMP=12, RES=13, LEA=14, TRAP=15, JSRR=16, RET=17.
REQ-014 pc_next  output  16  fetched address + 1.
REQ-015 dec_valid  output  1  ir/opcode/pc_next valid for the control FSM (DECODE).
REQ-016 dec_ack  input  1  control FSM consumed the decoded instruction.
REQ-017 illegal  output  1  opcode is RES; valid with dec_valid.
REQ-018 fetch_err  output  1  one-cycle pulse: fetch aborted on timeout.

Function
REQ-019 The block SHALL implement FSM states IDLE, READ, HOLD.
REQ-020 IDLE: fetch_req=1 SHALL latch pc_in into the address register and move to READ next cycle; fetch_req=0 keeps IDLE.
REQ-021 READ: mem_rd=1 and mem_addr=address register every cycle; other states drive mem_rd=0, mem_addr holds last address.
REQ-022 READ with mem_rdy=1 SHALL capture mem_rdata into ir, compute opcode/pc_next/illegal, clear wait counter, and move to HOLD next cycle.
REQ-023 Minimum latency: fetch_req in cycle N, mem_rdy in N+1 -> dec_valid=1 in N+2.
REQ-024 READ SHALL count cycles with mem_rdy=0; on the TIMEOUT-th such cycle SHALL pulse fetch_err for one cycle, leave ir unchanged, and return to IDLE.
REQ-025 HOLD: dec_valid=1; ir, opcode, pc_next, illegal stable until dec_ack.
REQ-026 HOLD with dec_ack=1 and fetch_req=0 -> IDLE; with dec_ack=1 and fetch_req=1 -> latch pc_in, go directly to READ (back-to-back, no IDLE bubble).
REQ-027 fetch_req SHALL be ignored in READ and in HOLD without dec_ack; dec_ack SHALL be ignored outside HOLD.
REQ-028 Decode from ir[15:12] per REQ-013 numbering, except: 4'b0100 with ir[11]=0 -> JSRR (16); 4'b1100 with ir[8:6]=3'b111 -> RET (17).
REQ-029 pc_next SHALL equal latched address + 1 modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-030 illegal SHALL be 1 iff opcode=RES (ir[15:12]=4'b1101); the block still presents it with dec_valid=1.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-READ; any pending mem_rdy response is discarded.
REQ-032 Reset values: mem_rd=0, mem_addr=RESET_PC, ir=16'h0000, opcode=0, pc_next=16'h0000, dec_valid=0, illegal=0, fetch_err=0, wait counter=0.
REQ-033 fetch_req asserted in the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-034 pc_in=16'h3000, fetch_req 1 cycle, mem_rdata=16'h1261 with mem_rdy next cycle -> dec_valid two cycles after fetch_req, opcode=1 (ADD), pc_next=16'h3001.
REQ-035 ir=16'h4080 -> opcode=16 (JSRR); ir=16'h4800 -> 4 (JSR); ir=16'hC1C0 -> 17 (RET); ir=16'hC080 -> 12 (JMP); ir=16'hD000 -> 13, illegal=1.
REQ-036 mem_rdy held 0 with TIMEOUT=16 -> mem_rd=1 for exactly 16 cycles, fetch_err pulse on the 16th, IDLE after, dec_valid never 1.
REQ-037 HOLD with dec_ack and fetch_req together, pc_in=16'h3001 -> next cycle mem_rd=1, mem_addr=16'h3001, no idle cycle.
REQ-038 pc_in=16'hFFFF fetch -> pc_next=16'h0000.
REQ-039 rst asserted during READ, then mem_rdy=1 -> dec_valid stays 0, mem_rd=0, ir=16'h0000.
